pc_gen: RTL and testbench

Parametrised program-counter generator for the pipelined CPU, the successor to the single-input PC register. It holds the fetch PC and selects the next one from a sequential increment, ID-stage jumps, EX-stage taken branches and a pipeline flush. It also provides a small return-address stack (RAS) that predicts the targets of returns. It sits at the head of IF, drives the instruction-memory address, and takes redirects from ID, EX and the hazard/exception control.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_gen.sv | 99 +++++++++
 tb/tb_pc_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared CPU constants and the next-PC source encoding used by the fetch PC generator.
package pc_gen_pkg;

  localparam int unsigned CPU_WIDTH_I     = 32;
  localparam logic [31:0] CPU_RESET_VEC   = 32'h0000_0000;
  localparam int unsigned CPU_INSTR_BYTES = 4;
  localparam int unsigned CPU_RAS_DEPTH   = 4;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_FLUSH,
    NPC_PEND,
    NPC_BR,
    NPC_RAS,
    NPC_JMP,
    NPC_SEQ
  } npc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with saturating count; oldest entry is overwritten when full.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic [PW:0]      count;
  logic             pop_ok;
  logic             full;

  assign pop_ok   = pop && (count != '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign top_data = mem[top];

  // top starts at the last slot so the first push lands in slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top   <= '1;
      count <= '0;
    end else if (push && pop_ok) begin
      top   <= top;
      count <= count;
    end else if (push) begin
      top <= top + PW'(1);
      if (!full)
        count <= count + (PW+1)'(1);
    end else if (pop_ok) begin
      top   <= top - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  // push with pop replaces the current top instead of advancing
  always_ff @(posedge clk) begin
    if (push) begin
      if (pop_ok)
        mem[top] <= push_data;
      else
        mem[top + PW'(1)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with prioritised redirects, stall-time branch latch and return-address prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned          WIDTH_I     = CPU_WIDTH_I,
  parameter logic [WIDTH_I-1:0]   RESET_VEC   = WIDTH_I'(CPU_RESET_VEC),
  parameter int unsigned          INSTR_BYTES = CPU_INSTR_BYTES,
  parameter int unsigned          RAS_DEPTH   = CPU_RAS_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_ctrl,
  input  logic               flush_valid,
  input  logic [WIDTH_I-1:0] flush_target,
  input  logic               br_taken,
  input  logic [WIDTH_I-1:0] br_target,
  input  logic               jmp_valid,
  input  logic [WIDTH_I-1:0] jmp_target,
  input  logic               call_valid,
  input  logic [WIDTH_I-1:0] call_ret_addr,
  input  logic               ret_valid,
  output logic [WIDTH_I-1:0] pc_addr,
  output logic               redirect_pending,
  output logic               ras_empty
);

  logic               pend_valid;
  logic [WIDTH_I-1:0] pend_target;
  logic [WIDTH_I-1:0] ras_top;
  logic               accept;
  logic               ras_push;
  logic               ras_pop;
  npc_src_e           src;
  logic [WIDTH_I-1:0] pc_next;

  assign accept   = !stall_ctrl && !flush_valid && !br_taken && !pend_valid;
  assign ras_push = accept && call_valid;
  assign ras_pop  = accept && ret_valid && !ras_empty;

  pc_ras #(
    .WIDTH (WIDTH_I),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (call_ret_addr),
    .top_data  (ras_top),
    .empty     (ras_empty)
  );

  // A fresh br_taken outranks the latched one: it comes from the younger resolve
  always_comb begin
    src = NPC_SEQ;
    if (flush_valid)             src = NPC_FLUSH;
    else if (stall_ctrl)         src = NPC_HOLD;
    else if (br_taken)           src = NPC_BR;
    else if (pend_valid)         src = NPC_PEND;
    else if (ret_valid && !ras_empty) src = NPC_RAS;
    else if (ret_valid || jmp_valid)  src = NPC_JMP;
  end

  always_comb begin
    pc_next = pc_addr + WIDTH_I'(INSTR_BYTES);
    unique case (src)
      NPC_HOLD:  pc_next = pc_addr;
      NPC_FLUSH: pc_next = flush_target;
      NPC_PEND:  pc_next = pend_target;
      NPC_BR:    pc_next = br_target;
      NPC_RAS:   pc_next = ras_top;
      NPC_JMP:   pc_next = jmp_target;
      default:   pc_next = pc_addr + WIDTH_I'(INSTR_BYTES);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_addr     <= RESET_VEC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      pc_addr <= pc_next;
      if (flush_valid) begin
        pend_valid <= 1'b0;
      end else if (stall_ctrl) begin
        if (br_taken) begin
          pend_valid  <= 1'b1;
          pend_target <= br_target;
        end
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign redirect_pending = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed cycles push expected PC/pending/empty, a negedge monitor compares.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ctrl, flush_valid, br_taken, jmp_valid, call_valid, ret_valid;
  logic [31:0] flush_target, br_target, jmp_target, call_ret_addr;
  logic [31:0] pc_addr;
  logic        redirect_pending, ras_empty;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pend;
    logic        empty;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pc_gen #(
    .WIDTH_I     (32),
    .RESET_VEC   (32'h0),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_ctrl       (stall_ctrl),
    .flush_valid      (flush_valid),
    .flush_target     (flush_target),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jmp_valid        (jmp_valid),
    .jmp_target       (jmp_target),
    .call_valid       (call_valid),
    .call_ret_addr    (call_ret_addr),
    .ret_valid        (ret_valid),
    .pc_addr          (pc_addr),
    .redirect_pending (redirect_pending),
    .ras_empty        (ras_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall_ctrl = 0; flush_valid = 0; br_taken = 0; jmp_valid = 0;
    call_valid = 0; ret_valid = 0;
    flush_target = '0; br_target = '0; jmp_target = 32'h300; call_ret_addr = '0;
  endtask

  task automatic tick(input string name, input logic [31:0] pc, input logic pend, input logic empty);
    exp_t e;
    @(posedge clk);
    e.name = name; e.pc = pc; e.pend = pend; e.empty = empty;
    sb.push_back(e);
    #1 clear_inputs();
  endtask

  task automatic do_call(input logic [31:0] ra, input logic [31:0] tgt, input logic empty_after);
    jmp_valid = 1; call_valid = 1; call_ret_addr = ra; jmp_target = tgt;
    tick("call", tgt, 1'b0, empty_after);
  endtask

  task automatic do_ret(input logic [31:0] pc, input logic empty_after);
    ret_valid = 1; jmp_valid = 1; jmp_target = 32'h300;
    tick("ret", pc, 1'b0, empty_after);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".pc"},    pc_addr,                 e.pc);
        chk({e.name, ".pend"},  {31'b0, redirect_pending}, {31'b0, e.pend});
        chk({e.name, ".empty"}, {31'b0, ras_empty},        {31'b0, e.empty});
      end
    end
  end

  initial begin : stim
    int wait_cycles;
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pc_addr, 32'h0);
    chk("reset.pend", {31'b0, redirect_pending}, 32'h0);
    chk("reset.empty", {31'b0, ras_empty}, 32'h1);
    rst = 0;

    tick("seq", 32'h4, 0, 1);
    tick("seq", 32'h8, 0, 1);
    tick("seq", 32'hC, 0, 1);
    tick("seq", 32'h10, 0, 1);

    // branch latched during stall, applied on release
    stall_ctrl = 1; br_taken = 1; br_target = 32'h200;
    tick("stall_br", 32'h10, 1, 1);
    stall_ctrl = 1;
    tick("stall_hold", 32'h10, 1, 1);
    tick("pend_apply", 32'h200, 0, 1);

    // flush beats stall and discards pending branch
    stall_ctrl = 1; br_taken = 1; br_target = 32'h200;
    tick("stall_br2", 32'h200, 1, 1);
    stall_ctrl = 1; flush_valid = 1; flush_target = 32'h80;
    tick("flush", 32'h80, 0, 1);
    tick("post_flush", 32'h84, 0, 1);

    // later branch in same stall overwrites the latch
    stall_ctrl = 1; br_taken = 1; br_target = 32'h400;
    tick("stall_br3", 32'h84, 1, 1);
    stall_ctrl = 1; br_taken = 1; br_target = 32'h500;
    tick("stall_br4", 32'h84, 1, 1);
    tick("pend_over", 32'h500, 0, 1);

    // fresh branch wins over latched one
    stall_ctrl = 1; br_taken = 1; br_target = 32'h600;
    tick("stall_br5", 32'h500, 1, 1);
    br_taken = 1; br_target = 32'h700;
    tick("br_vs_pend", 32'h700, 0, 1);

    do_call(32'h44, 32'h1000, 0);
    do_call(32'h88, 32'h2000, 0);
    do_ret(32'h88, 0);
    do_ret(32'h44, 1);
    do_ret(32'h300, 1);

    // call ignored under stall and under a branch
    stall_ctrl = 1; jmp_valid = 1; call_valid = 1; call_ret_addr = 32'h99; jmp_target = 32'h3000;
    tick("stall_call", 32'h300, 0, 1);
    br_taken = 1; br_target = 32'h400; jmp_valid = 1; call_valid = 1; call_ret_addr = 32'h99;
    tick("br_call", 32'h400, 0, 1);

    // overflow: oldest (0x10) lost
    do_call(32'h10, 32'h1100, 0);
    do_call(32'h20, 32'h1200, 0);
    do_call(32'h30, 32'h1300, 0);
    do_call(32'h40, 32'h1400, 0);
    do_call(32'h50, 32'h1500, 0);
    do_ret(32'h50, 0);
    do_ret(32'h40, 0);
    do_ret(32'h30, 0);
    do_ret(32'h20, 1);
    do_ret(32'h300, 1);

    // call+ret replaces top; on empty stack it is a push
    do_call(32'hA0, 32'h900, 0);
    ret_valid = 1; call_valid = 1; jmp_valid = 1; call_ret_addr = 32'hB0; jmp_target = 32'h950;
    tick("replace", 32'hA0, 0, 0);
    do_ret(32'hB0, 1);
    ret_valid = 1; call_valid = 1; jmp_valid = 1; call_ret_addr = 32'hC0; jmp_target = 32'h960;
    tick("replace_empty", 32'h960, 0, 0);
    do_ret(32'hC0, 1);

    flush_valid = 1; flush_target = 32'hFFFF_FFF8;
    tick("flush_hi", 32'hFFFF_FFF8, 0, 1);
    tick("seq_hi", 32'hFFFF_FFFC, 0, 1);
    tick("wrap", 32'h0, 0, 1);

    // asynchronous reset with a pending redirect and a live RAS entry
    do_call(32'h55, 32'h40, 0);
    stall_ctrl = 1; br_taken = 1; br_target = 32'h123;
    tick("stall_pre_rst", 32'h40, 1, 0);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("async_rst.pc", pc_addr, 32'h0);
    chk("async_rst.pend", {31'b0, redirect_pending}, 32'h0);
    chk("async_rst.empty", {31'b0, ras_empty}, 32'h1);
    rst = 0;
    tick("post_rst", 32'h4, 0, 1);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
